// File: rtl/clkdiv_sched.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_sched
// Description : Programmable slow-clock generator with run/stop/burst control.
//               Commands arrive over valid/ready and only take effect on a
//               full-period boundary, so slow_clk never produces a runt pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_sched #(
    parameter int WIDTH   = 32,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [WIDTH-1:0]   cfg_half,
    input  logic [BURST_W-1:0] cfg_count,
    output logic               slow_clk,
    output logic               tick,
    output logic               active,
    output logic               done
);

    localparam logic [1:0] c_MODE_RUN   = 2'b01;
    localparam logic [1:0] c_MODE_BURST = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BURST = 2'b10
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_count;
    logic [WIDTH-1:0]     r_half;
    logic [BURST_W-1:0]   r_remaining;
    logic                 r_slow_clk;
    logic                 r_tick;
    logic                 r_done;

    logic                 r_pend_valid;
    logic [1:0]           r_pend_mode;
    logic [WIDTH-1:0]     r_pend_half;
    logic [BURST_W-1:0]   r_pend_count;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_cfg_half;
    logic [1:0]           w_cmd_mode;
    logic [WIDTH-1:0]     w_cmd_half;
    logic [BURST_W-1:0]   w_cmd_count;
    logic                 w_cmd_go;
    logic                 w_cmd_empty_burst;
    logic                 w_half_end;

    assign w_accept   = cfg_valid && !r_pend_valid;
    assign w_cfg_half = (cfg_half == '0) ? WIDTH'(1) : cfg_half;

    // The command to launch: pending entry if one is held, else the live input.
    assign w_cmd_mode  = r_pend_valid ? r_pend_mode  : cfg_mode;
    assign w_cmd_half  = r_pend_valid ? r_pend_half  : w_cfg_half;
    assign w_cmd_count = r_pend_valid ? r_pend_count : cfg_count;

    assign w_cmd_go          = (w_cmd_mode == c_MODE_RUN) ||
                               ((w_cmd_mode == c_MODE_BURST) && (w_cmd_count != '0));
    assign w_cmd_empty_burst = (w_cmd_mode == c_MODE_BURST) && (w_cmd_count == '0);
    assign w_half_end        = (r_count == (r_half - WIDTH'(1)));

    assign cfg_ready = !r_pend_valid;
    assign active    = (r_state != ST_IDLE);
    assign slow_clk  = r_slow_clk;
    assign tick      = r_tick;
    assign done      = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_half       <= WIDTH'(1);
            r_remaining  <= '0;
            r_slow_clk   <= 1'b0;
            r_tick       <= 1'b0;
            r_done       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_mode  <= 2'b00;
            r_pend_half  <= WIDTH'(1);
            r_pend_count <= '0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;

            // While running, commands queue until the next boundary.
            if (w_accept && (r_state != ST_IDLE)) begin
                r_pend_valid <= 1'b1;
                r_pend_mode  <= cfg_mode;
                r_pend_half  <= w_cfg_half;
                r_pend_count <= cfg_count;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend_valid || w_accept) begin
                        r_pend_valid <= 1'b0;
                        if (w_cmd_go) begin
                            r_state     <= (w_cmd_mode == c_MODE_BURST) ? ST_BURST : ST_RUN;
                            r_slow_clk  <= 1'b1;
                            r_tick      <= 1'b1;
                            r_count     <= '0;
                            r_half      <= w_cmd_half;
                            r_remaining <= (w_cmd_mode == c_MODE_BURST) ?
                                           (w_cmd_count - BURST_W'(1)) : '0;
                        end else begin
                            r_done <= w_cmd_empty_burst;
                        end
                    end
                end

                ST_RUN, ST_BURST: begin
                    if (!w_half_end) begin
                        r_count <= r_count + WIDTH'(1);
                    end else if (r_slow_clk) begin
                        r_count    <= '0;
                        r_slow_clk <= 1'b0;
                    end else begin
                        // Boundary: the next rising edge is due.
                        r_count <= '0;
                        if (r_pend_valid) begin
                            r_pend_valid <= 1'b0;
                            if (w_cmd_go) begin
                                r_state     <= (w_cmd_mode == c_MODE_BURST) ? ST_BURST : ST_RUN;
                                r_slow_clk  <= 1'b1;
                                r_tick      <= 1'b1;
                                r_half      <= w_cmd_half;
                                r_remaining <= (w_cmd_mode == c_MODE_BURST) ?
                                               (w_cmd_count - BURST_W'(1)) : '0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_done  <= w_cmd_empty_burst;
                            end
                        end else if ((r_state == ST_BURST) && (r_remaining == '0)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_slow_clk <= 1'b1;
                            r_tick     <= 1'b1;
                            if (r_state == ST_BURST) begin
                                r_remaining <= r_remaining - BURST_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_clkdiv_sched
// Description : Scoreboard bench for clkdiv_sched against a period-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clkdiv_sched;

    localparam int WIDTH   = 32;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [1:0]         cfg_mode = 2'b00;
    logic [WIDTH-1:0]   cfg_half = '0;
    logic [BURST_W-1:0] cfg_count = '0;
    logic               cfg_ready;
    logic               slow_clk;
    logic               tick;
    logic               active;
    logic               done;

    clkdiv_sched #(.WIDTH(WIDTH), .BURST_W(BURST_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_half  (cfg_half),
        .cfg_count (cfg_count),
        .slow_clk  (slow_clk),
        .tick      (tick),
        .active    (active),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int cyc;
        bit is_done;
    } ev_t;
    ev_t exp_q[$];

    // Reference model: one period spans 2*half cycles counted from its rising edge.
    int     cyc;
    int     m_state;      // 0 idle, 1 run, 2 burst
    longint m_half;
    longint m_phase;
    int     m_left;
    bit     m_pend;
    int     p_mode;
    longint p_half;
    int     p_count;
    bit     m_acc;
    bit     m_had;

    function automatic void m_start(int mode, longint h, int n);
        if (mode == 1 || (mode == 2 && n > 0)) begin
            m_state = mode;
            m_half  = (h == 0) ? 1 : h;
            m_phase = 0;
            m_left  = n - 1;
            exp_q.push_back('{cyc, 1'b0});
        end else begin
            m_state = 0;
            if (mode == 2) exp_q.push_back('{cyc, 1'b1});
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_half = 1; m_phase = 0; m_left = 0; m_pend = 0; cyc = 0;
            exp_q.delete();
        end else begin
            cyc++;
            m_acc = cfg_valid && !m_pend;
            m_had = m_pend;
            if (m_state == 0) begin
                if (m_had) begin
                    m_pend = 0;
                    m_start(p_mode, p_half, p_count);
                end else if (m_acc) begin
                    m_start(int'(cfg_mode), longint'(cfg_half), int'(cfg_count));
                end
            end else begin
                m_phase++;
                if (m_phase == 2 * m_half) begin
                    if (m_had) begin
                        m_pend = 0;
                        m_start(p_mode, p_half, p_count);
                    end else if (m_state == 2 && m_left == 0) begin
                        m_state = 0;
                        exp_q.push_back('{cyc, 1'b1});
                    end else begin
                        m_phase = 0;
                        m_left--;
                        exp_q.push_back('{cyc, 1'b0});
                    end
                end
                if (m_acc) begin
                    m_pend  = 1;
                    p_mode  = int'(cfg_mode);
                    p_half  = longint'(cfg_half);
                    p_count = int'(cfg_count);
                end
            end
        end
    end

    function automatic void check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endfunction

    // Monitor: level outputs every cycle, pulse events popped from the scoreboard.
    ev_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            check("slow_clk", slow_clk, (m_state != 0) && (m_phase < m_half));
            check("active", active, m_state != 0);
            check("cfg_ready", cfg_ready, !m_pend);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++; failures++;
                $display("FAIL missing_event cyc=%0d expected %s at cyc=%0d", cyc,
                         e.is_done ? "done" : "tick", e.cyc);
            end
            if (tick || done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d tick=%b done=%b, none expected",
                             cyc, tick, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || tick !== !e.is_done || done !== e.is_done) begin
                        failures++;
                        $display("FAIL event cyc=%0d tick=%b done=%b expected %s at cyc=%0d",
                                 cyc, tick, done, e.is_done ? "done" : "tick", e.cyc);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_slow_clk"}, slow_clk, 1'b0);
        check({tag, "_tick"}, tick, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_active"}, active, 1'b0);
        check({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    endtask

    // Called on a falling edge; returns on a falling edge after acceptance.
    task automatic send(input logic [1:0] mode, input int half, input int count);
        bit got = 0;
        cfg_valid = 1'b1;
        cfg_mode  = mode;
        cfg_half  = WIDTH'(half);
        cfg_count = BURST_W'(count);
        for (int i = 0; i < 500; i++) begin
            if (cfg_ready) begin
                @(posedge clk);
                got = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL send_timeout mode=%0d cfg_ready stayed 0", mode);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (!active && cfg_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL idle_timeout active=%b cfg_ready=%b expected 0/1", active, cfg_ready);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // RUN half=4, retune to half=2 mid-high-phase, then stop.
        send(2'b01, 4, 0);
        repeat (2) @(negedge clk);
        send(2'b01, 2, 0);
        repeat (20) @(negedge clk);
        send(2'b00, 0, 0);
        wait_idle();

        // Bursts: N=3, then N=0.
        send(2'b10, 2, 3);
        wait_idle();
        send(2'b10, 5, 0);
        repeat (3) @(negedge clk);

        // half=0 behaves as half=1.
        send(2'b01, 0, 0);
        repeat (10) @(negedge clk);
        send(2'b00, 0, 0);
        wait_idle();

        // RUN half=3 then STOP.
        send(2'b01, 3, 0);
        repeat (4) @(negedge clk);
        send(2'b00, 0, 0);
        wait_idle();

        // Asynchronous reset mid-high-phase of a burst.
        send(2'b10, 3, 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2'b01, 2, 0);
        repeat (10) @(negedge clk);
        send(2'b00, 0, 0);
        wait_idle();

        // Randomized command traffic.
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_half  = WIDTH'($urandom_range(0, 6));
            cfg_count = BURST_W'($urandom_range(0, 4));
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        send(2'b00, 0, 0);
        wait_idle();
        repeat (5) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_events actual=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
